// File: rtl/stepper_move_ctrl.sv
// Motion-command front end: takes a signed relative move, emits direction plus
// step strobes on a linear trapezoidal speed ramp, tracks position, reports done.
module stepper_move_ctrl #(
  parameter int POS_W        = 24,
  parameter int PER_W        = 20,
  parameter int START_PERIOD = 160000,
  parameter int MIN_PERIOD   = 20000,
  parameter int RAMP_STEP    = 4000,
  parameter int HOLD_CYCLES  = 50000
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             zero_pos,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             motor_en,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [PER_W-1:0]  P_START   = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0]  P_MIN     = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0]  P_RAMP    = PER_W'(RAMP_STEP);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, SETTLE} state_t;

  state_t            state, state_next;
  logic [16:0]       remaining, remaining_next;
  logic [16:0]       ramp_cnt, ramp_cnt_next;
  logic [16:0]       rem_dec;
  logic [PER_W-1:0]  target, target_next;
  logic [PER_W-1:0]  period, period_next;
  logic [PER_W-1:0]  timer, timer_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [POS_W-1:0]  position_next;
  logic              step_dir_next, motor_en_next, busy_next;

  logic              moving;
  logic [16:0]       steps_ext, steps_abs;
  logic [PER_W-1:0]  period_clamped;
  logic [PER_W:0]    up_sum;
  logic [PER_W-1:0]  period_up, period_down;
  logic              accel_hit;

  assign moving     = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
  assign step_pulse = moving && (timer == PER_W'(1));
  assign done       = (state == SETTLE) && (hold_cnt == HOLD_W'(1));

  assign steps_ext = {cmd_steps[15], cmd_steps};
  assign steps_abs = cmd_steps[15] ? (17'd0 - steps_ext) : steps_ext;
  assign period_clamped = (cmd_period < P_MIN)   ? P_MIN :
                          (cmd_period > P_START) ? P_START : cmd_period;

  // Widened compares keep the ramp arithmetic free of wrap-around at the ends.
  assign up_sum      = {1'b0, period} + {1'b0, P_RAMP};
  assign period_up   = (up_sum >= {1'b0, P_START}) ? P_START : up_sum[PER_W-1:0];
  assign period_down = period - P_RAMP;
  assign accel_hit   = ({1'b0, period} <= ({1'b0, target} + {1'b0, P_RAMP}));

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      remaining <= '0;
      ramp_cnt  <= '0;
      target    <= '0;
      period    <= '0;
      timer     <= '0;
      hold_cnt  <= '0;
      position  <= '0;
      step_dir  <= 1'b0;
      motor_en  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      remaining <= remaining_next;
      ramp_cnt  <= ramp_cnt_next;
      target    <= target_next;
      period    <= period_next;
      timer     <= timer_next;
      hold_cnt  <= hold_next;
      position  <= position_next;
      step_dir  <= step_dir_next;
      motor_en  <= motor_en_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    ramp_cnt_next  = ramp_cnt;
    target_next    = target;
    period_next    = period;
    timer_next     = timer;
    hold_next      = hold_cnt;
    position_next  = position;
    step_dir_next  = step_dir;
    motor_en_next  = motor_en;
    busy_next      = busy;
    rem_dec        = remaining - 17'd1;

    case (state)
      IDLE: begin
        if (zero_pos) position_next = '0;
        if (cmd_valid && cmd_ready) begin
          step_dir_next  = ~cmd_steps[15];
          remaining_next = steps_abs;
          target_next    = period_clamped;
          period_next    = P_START;
          timer_next     = P_START;
          ramp_cnt_next  = '0;
          motor_en_next  = 1'b1;
          busy_next      = 1'b1;
          if (cmd_steps == 16'd0) begin
            state_next = SETTLE;
            hold_next  = HOLD_LOAD;
          end else begin
            state_next = (period_clamped == P_START) ? CRUISE : ACCEL;
          end
        end
      end

      ACCEL, CRUISE, DECEL: begin
        timer_next = timer - PER_W'(1);
        if (timer == PER_W'(1)) begin
          position_next  = step_dir ? position + POS_W'(1) : position - POS_W'(1);
          remaining_next = rem_dec;
          if (rem_dec == 17'd0) begin
            state_next = SETTLE;
            hold_next  = HOLD_LOAD;
          end else if ((state != DECEL) && (rem_dec <= ramp_cnt)) begin
            state_next    = DECEL;
            period_next   = period_up;
            ramp_cnt_next = ramp_cnt - 17'd1;
          end else if (state == ACCEL) begin
            ramp_cnt_next = ramp_cnt + 17'd1;
            if (accel_hit) begin
              period_next = target;
              state_next  = CRUISE;
            end else begin
              period_next = period_down;
            end
          end else if (state == DECEL) begin
            period_next = period_up;
            if (ramp_cnt != 17'd0) ramp_cnt_next = ramp_cnt - 17'd1;
          end
          timer_next = period_next;
        end
        // Abort shortens the move to exactly the steps needed to ramp back down.
        if (abort && ((state_next == ACCEL) || (state_next == CRUISE)) &&
            (({1'b0, ramp_cnt_next} + 18'd1) < {1'b0, remaining_next})) begin
          remaining_next = ramp_cnt_next + 17'd1;
        end
      end

      SETTLE: begin
        hold_next = hold_cnt - HOLD_W'(1);
        if (hold_cnt == HOLD_W'(1)) begin
          state_next    = IDLE;
          motor_en_next = 1'b0;
          busy_next     = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl: directed moves push expected pulse
// gaps and completion data; a negedge monitor pops and compares.
module tb_stepper_move_ctrl;
  localparam int PER_W = 20;
  localparam int POS_W = 24;
  localparam int HOLD  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [15:0]      cmd_steps = '0;
  logic [PER_W-1:0] cmd_period = '0;
  logic             abort = 1'b0;
  logic             zero_pos = 1'b0;
  logic             step_pulse, step_dir, motor_en, busy, done;
  logic [POS_W-1:0] position;

  stepper_move_ctrl #(
    .POS_W(POS_W), .PER_W(PER_W), .START_PERIOD(20), .MIN_PERIOD(5),
    .RAMP_STEP(5), .HOLD_CYCLES(HOLD)
  ) dut (
    .CLK_50M(clk), .RST_N(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .zero_pos(zero_pos), .step_pulse(step_pulse), .step_dir(step_dir),
    .motor_en(motor_en), .busy(busy), .done(done), .position(position)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int gap;
    bit dir;
    int pos;
  } exp_t;

  exp_t exp_q[$];
  int   gap_tab[$];
  int   checks = 0, fails = 0;
  int   cyc = 0, last_ref = 0, pulse_cnt = 0, done_cnt = 0;
  exp_t e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: measures gaps from acceptance or previous pulse.
  always @(negedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready) last_ref = cyc;
    if (step_pulse) begin
      pulse_cnt++;
      if (exp_q.size() == 0 || exp_q[0].is_done) fail_now("unexpected_pulse");
      else begin
        e = exp_q.pop_front();
        check("pulse_gap", cyc - last_ref, e.gap);
        check("pulse_dir", int'(step_dir), int'(e.dir));
        $display("pulse %0d: gap %0d dir %0d", pulse_cnt, cyc - last_ref, step_dir);
      end
      last_ref = cyc;
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0 || !exp_q[0].is_done) fail_now("unexpected_done");
      else begin
        e = exp_q.pop_front();
        check("done_gap", cyc - last_ref, e.gap);
        check("done_pos", int'($signed(position)), e.pos);
        check("done_dir", int'(step_dir), int'(e.dir));
        check("done_motor_en", int'(motor_en), 1);
        $display("done: gap %0d pos %0d", cyc - last_ref, $signed(position));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_move(input bit dir, input int pos, input bit with_done);
    exp_t x;
    foreach (gap_tab[i]) begin
      x.is_done = 1'b0; x.gap = gap_tab[i]; x.dir = dir; x.pos = 0;
      exp_q.push_back(x);
    end
    if (with_done) begin
      x.is_done = 1'b1; x.gap = HOLD; x.dir = dir; x.pos = pos;
      exp_q.push_back(x);
    end
  endtask

  task automatic send(input int steps, input int per, input bit zp);
    int n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) fail_now("ready_timeout");
    cmd_valid  = 1'b1;
    cmd_steps  = 16'(steps);
    cmd_period = PER_W'(per);
    zero_pos   = zp;
    tick();
    cmd_valid = 1'b0;
    zero_pos  = 1'b0;
    $display("cmd: steps %0d period %0d zero_pos %0d", steps, per, zp);
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 3000) begin tick(); n++; end
    if (done_cnt == start) fail_now("done_timeout");
    else begin
      check("ready_after_done", int'(cmd_ready), 1);
      check("motor_off_after_done", int'(motor_en), 0);
      check("busy_off_after_done", int'(busy), 0);
    end
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (pulse_cnt < target && n < 3000) begin tick(); n++; end
    if (pulse_cnt < target) fail_now("pulse_timeout");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 0);
    check({tag, "_step_pulse"}, int'(step_pulse), 0);
    check({tag, "_step_dir"}, int'(step_dir), 0);
    check({tag, "_motor_en"}, int'(motor_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_position"}, int'(position), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("ready_at_release", int'(cmd_ready), 0);
    tick();
    check("ready_after_release", int'(cmd_ready), 1);

    // Short move
    gap_tab = '{20, 15, 20};
    expect_move(1'b1, 3, 1'b1);
    send(3, 10, 1'b0);
    check("busy_during_move", int'(busy), 1);
    check("motor_en_during_move", int'(motor_en), 1);
    check("dir_after_accept", int'(step_dir), 1);
    wait_done();

    // Full trapezoid, reverse
    gap_tab = '{20, 15, 10, 10, 10, 10, 10, 10, 15, 20};
    expect_move(1'b0, -7, 1'b1);
    send(-10, 10, 1'b0);
    wait_done();

    // Abort while cruising
    gap_tab = '{20, 15, 10, 10, 15, 20};
    expect_move(1'b1, -1, 1'b1);
    send(100, 10, 1'b0);
    wait_pulses(pulse_cnt + 3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done();

    // Cruise period clamped up to the minimum
    gap_tab = '{20, 15, 10, 5, 5, 5, 5, 10, 15, 20};
    expect_move(1'b1, 9, 1'b1);
    send(10, 2, 1'b0);
    wait_done();

    // Cruise period clamped down to the start period: no ramp at all
    gap_tab = '{20, 20, 20};
    expect_move(1'b1, 12, 1'b1);
    send(3, 50, 1'b0);
    wait_done();

    // Zero-step move
    gap_tab = {};
    expect_move(1'b1, 12, 1'b1);
    send(0, 10, 1'b0);
    wait_done();

    // Position clear while idle
    zero_pos = 1'b1;
    tick();
    zero_pos = 1'b0;
    check("zero_pos_idle", int'($signed(position)), 0);

    // zero_pos during a move is ignored
    gap_tab = '{20, 20, 20};
    expect_move(1'b1, 3, 1'b1);
    send(3, 50, 1'b0);
    repeat (5) tick();
    zero_pos = 1'b1;
    repeat (40) tick();
    zero_pos = 1'b0;
    wait_done();

    // zero_pos coincident with acceptance
    gap_tab = '{20};
    expect_move(1'b0, -1, 1'b1);
    send(-1, 10, 1'b1);
    wait_done();

    // Reset in the middle of a cruise
    gap_tab = '{20, 15, 10, 10};
    expect_move(1'b1, 0, 1'b0);
    send(100, 10, 1'b0);
    wait_pulses(pulse_cnt + 4);
    check("queue_drained_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("ready_at_release2", int'(cmd_ready), 0);
    tick();
    check("ready_after_release2", int'(cmd_ready), 1);
    gap_tab = '{20, 15};
    expect_move(1'b1, 2, 1'b1);
    send(2, 10, 1'b0);
    wait_done();

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
